// File: rtl/memory_stage_hs_pkg.sv
// Shared pipeline definitions: memory-stage FSM encoding, datapath width default
// and the M/W register bundle consumed by the writeback stage.
package memory_stage_hs_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_BUSY = 1'b1
    } ms_state_e;

    typedef struct packed {
        logic                    reg_write;
        logic                    result_src;
        logic [4:0]              rd;
        logic [XLEN_DEFAULT-1:0] alu_result;
        logic [XLEN_DEFAULT-1:0] read_data;
        logic [XLEN_DEFAULT-1:0] pc_plus4;
        logic                    misalign;
    } mw_bundle_t;

endpackage

// File: rtl/memory_stage_hs_if.sv
// Data-memory request/acknowledge port between the memory stage (master) and memory (slave).
import memory_stage_hs_pkg::*;

interface memory_stage_hs_if #(
    parameter int XLEN = XLEN_DEFAULT
);
    // Handshake: the master raises dmem_req with we/addr/wdata and holds all of them
    // stable until the cycle dmem_ack=1; that cycle completes the access and carries
    // dmem_rdata for reads. dmem_ack while dmem_req=0 has no meaning and is ignored.
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/memory_stage_hs.sv
// Memory stage with req/ack data port: issues loads/stores, stalls until ack, owns M/W.
// Optional MISALIGN_CHECK_EN: suppress misaligned word accesses and flag them in W.
module memory_stage_hs
    import memory_stage_hs_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    RegWriteM,
    input  logic                    MemWriteM,
    input  logic                    ResultSrcM,
    input  logic [4:0]              RD_M,
    input  logic [XLEN-1:0]         ALU_ResultM,
    input  logic [XLEN-1:0]         WriteDataM,
    input  logic [XLEN-1:0]         PCPlus4M,
    memory_stage_hs_if.master       dmem,
    output logic                    StallM,
    output logic                    RegWriteW,
    output logic                    ResultSrcW,
    output logic [4:0]              RD_W,
    output logic [XLEN-1:0]         ALU_ResultW,
    output logic [XLEN-1:0]         ReadDataW,
    output logic [XLEN-1:0]         PCPlus4W,
    output logic                    MisalignW,
    output ms_state_e               ms_state
);

    logic       is_load;
    logic       mem_op_raw;
    logic       misalign;
    logic       mem_op;
    logic       ack_v;
    ms_state_e  state_q;
    ms_state_e  state_d;
    mw_bundle_t mw_q;

    assign is_load    = RegWriteM & ResultSrcM;
    assign mem_op_raw = MemWriteM | is_load;

`ifdef MISALIGN_CHECK_EN
    assign misalign = mem_op_raw & (ALU_ResultM[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A misaligned op never reaches memory, so it can neither request nor stall.
    assign mem_op = mem_op_raw & ~misalign;
    assign ack_v  = mem_op & dmem.dmem_ack;

    assign dmem.dmem_req   = mem_op;
    assign dmem.dmem_we    = MemWriteM;
    assign dmem.dmem_addr  = ALU_ResultM;
    assign dmem.dmem_wdata = WriteDataM;

    assign StallM = mem_op & ~dmem.dmem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= MS_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MS_IDLE: if (mem_op && !dmem.dmem_ack) state_d = MS_BUSY;
            MS_BUSY: if (ack_v) state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    assign ms_state = state_q;

    // While stalled only the write-enable and flag are cleared; the rest holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mw_q <= '0;
        end else if (StallM) begin
            mw_q.reg_write <= 1'b0;
            mw_q.misalign  <= 1'b0;
        end else begin
            mw_q.reg_write  <= RegWriteM & ~misalign;
            mw_q.result_src <= ResultSrcM;
            mw_q.rd         <= RD_M;
            mw_q.alu_result <= ALU_ResultM;
            mw_q.pc_plus4   <= PCPlus4M;
            mw_q.misalign   <= misalign;
            if (is_load && ack_v) mw_q.read_data <= dmem.dmem_rdata;
        end
    end

    assign RegWriteW   = mw_q.reg_write;
    assign ResultSrcW  = mw_q.result_src;
    assign RD_W        = mw_q.rd;
    assign ALU_ResultW = mw_q.alu_result;
    assign ReadDataW   = mw_q.read_data;
    assign PCPlus4W    = mw_q.pc_plus4;
    assign MisalignW   = mw_q.misalign;

endmodule

// File: tb/tb_memory_stage_hs.sv
// Bench for memory_stage_hs: vector table, hand-written stall/reset/misalign sequences
// and a randomized instruction stream checked against a transaction-level model.
module tb_memory_stage_hs;
    import memory_stage_hs_pkg::*;

    localparam int XL = 32;
    localparam int WB = 1 + 1 + 5 + 3 * XL;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]    RD_M;
    logic [XL-1:0] ALU_ResultM, WriteDataM, PCPlus4M;
    logic          StallM, RegWriteW, ResultSrcW, MisalignW;
    logic [4:0]    RD_W;
    logic [XL-1:0] ALU_ResultW, ReadDataW, PCPlus4W;
    ms_state_e     ms_state;

    int checks   = 0;
    int failures = 0;
    logic [WB-1:0] exp_q[$];

    // random-section scratch
    int            kind;
    int            waits;
    logic          r_rw, r_mw, r_rs, is_mem;
    logic [4:0]    r_rd;
    logic [XL-1:0] r_alu, r_wd, r_pc4, r_rdata, model_rdata;
    logic [WB-1:0] exp_w, got_w;

    typedef struct {
        logic          rw, mw, rs;
        logic [4:0]    rd;
        logic [XL-1:0] alu, wd, pc4, rdata;
        logic          ack;
        logic          e_req, e_we, e_stall, e_rw_w, e_rs_w;
        logic [XL-1:0] e_rdw;
    } vec_t;
    vec_t vecs[5];

    memory_stage_hs_if #(.XLEN(XL)) dmem();

    memory_stage_hs #(.XLEN(XL)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .dmem(dmem),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .MisalignW(MisalignW), .ms_state(ms_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                           input logic [XL-1:0] alu, input logic [XL-1:0] wd, input logic [XL-1:0] pc4);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
        ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc4;
    endtask

    task automatic drive_mem(input logic ack, input logic [XL-1:0] rdata);
        dmem.dmem_ack   = ack;
        dmem.dmem_rdata = rdata;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_w_zero(input string tag);
        chk({tag, "_rw"},  32'(RegWriteW),  32'd0);
        chk({tag, "_rs"},  32'(ResultSrcW), 32'd0);
        chk({tag, "_rd"},  32'(RD_W),       32'd0);
        chk({tag, "_alu"}, ALU_ResultW,     32'd0);
        chk({tag, "_rdw"}, ReadDataW,       32'd0);
        chk({tag, "_pc4"}, PCPlus4W,        32'd0);
        chk({tag, "_mis"}, 32'(MisalignW),  32'd0);
        chk({tag, "_st"},  32'(ms_state),   32'(MS_IDLE));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd5, 32'h10,  32'h0,    32'h4,  32'h0,        1'b0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 5'd7, 32'h100, 32'h0,    32'h8,  32'hDEADBEEF, 1'b1,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h204, 32'hCAFE, 32'hC,  32'h11111111, 1'b1,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 5'd9, 32'h77,  32'h0,    32'h10, 32'h55,       1'b1,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,   32'h0,    32'h14, 32'h66,       1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};

        drive_m(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
        drive_mem(1'b0, '0);
        #12;
        chk_w_zero("reset");
        chk("reset_req",   32'(dmem.dmem_req), 32'd0);
        chk("reset_stall", 32'(StallM),        32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // table-driven single-cycle vectors
        for (int i = 0; i < 5; i++) begin
            drive_m(vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].rd, vecs[i].alu, vecs[i].wd, vecs[i].pc4);
            drive_mem(vecs[i].ack, vecs[i].rdata);
            #1;
            chk($sformatf("vec%0d_req", i),   32'(dmem.dmem_req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d_we", i),    32'(dmem.dmem_we),  32'(vecs[i].e_we));
            chk($sformatf("vec%0d_stall", i), 32'(StallM),        32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_addr", i),  dmem.dmem_addr,     vecs[i].alu);
            chk($sformatf("vec%0d_wdata", i), dmem.dmem_wdata,    vecs[i].wd);
            tick();
            chk($sformatf("vec%0d_rw_w", i),  32'(RegWriteW),     32'(vecs[i].e_rw_w));
            chk($sformatf("vec%0d_rs_w", i),  32'(ResultSrcW),    32'(vecs[i].e_rs_w));
            chk($sformatf("vec%0d_rd_w", i),  32'(RD_W),          32'(vecs[i].rd));
            chk($sformatf("vec%0d_alu_w", i), ALU_ResultW,        vecs[i].alu);
            chk($sformatf("vec%0d_rdw", i),   ReadDataW,          vecs[i].e_rdw);
            chk($sformatf("vec%0d_pc4_w", i), PCPlus4W,           vecs[i].pc4);
            chk($sformatf("vec%0d_mis_w", i), 32'(MisalignW),     32'd0);
        end

        // store with three wait states, preceded by an ALU op so bubbles are visible
        drive_m(1'b1, 1'b0, 1'b0, 5'd4, 32'h30, 32'h0, 32'h40);
        drive_mem(1'b0, '0);
        tick();
        drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h200, 32'h12345678, 32'h44);
        for (int k = 0; k < 3; k++) begin
            drive_mem(1'b0, $urandom);
            #1;
            chk("st3_req",   32'(dmem.dmem_req), 32'd1);
            chk("st3_we",    32'(dmem.dmem_we),  32'd1);
            chk("st3_stall", 32'(StallM),        32'd1);
            chk("st3_wdata", dmem.dmem_wdata,    32'h12345678);
            chk("st3_state_pre", 32'(ms_state), (k == 0) ? 32'(MS_IDLE) : 32'(MS_BUSY));
            tick();
            chk("st3_bubble_rw", 32'(RegWriteW), 32'd0);
            chk("st3_bubble_pc4", PCPlus4W,      32'h40);
            chk("st3_state",     32'(ms_state),  32'(MS_BUSY));
        end
        drive_mem(1'b1, $urandom);
        #1;
        chk("st3_ack_req",   32'(dmem.dmem_req), 32'd1);
        chk("st3_ack_stall", 32'(StallM),        32'd0);
        tick();
        chk("st3_done_state", 32'(ms_state), 32'(MS_IDLE));
        chk("st3_done_pc4",   PCPlus4W,      32'h44);
        chk("st3_done_alu",   ALU_ResultW,   32'h200);
        chk("st3_done_rdw",   ReadDataW,     32'hDEADBEEF);

        // back-to-back load (one wait) then store (zero wait)
        drive_m(1'b1, 1'b0, 1'b1, 5'd3, 32'h400, 32'h0, 32'h50);
        drive_mem(1'b0, 32'h0);
        #1;
        chk("b2b_ld_stall", 32'(StallM), 32'd1);
        tick();
        chk("b2b_ld_bubble", 32'(RegWriteW), 32'd0);
        chk("b2b_ld_busy",   32'(ms_state),  32'(MS_BUSY));
        drive_mem(1'b1, 32'hA5A50001);
        #1;
        chk("b2b_ld_ack_stall", 32'(StallM), 32'd0);
        tick();
        chk("b2b_ld_rw",  32'(RegWriteW),  32'd1);
        chk("b2b_ld_rs",  32'(ResultSrcW), 32'd1);
        chk("b2b_ld_rd",  32'(RD_W),       32'd3);
        chk("b2b_ld_rdw", ReadDataW,       32'hA5A50001);
        chk("b2b_ld_idle", 32'(ms_state),  32'(MS_IDLE));
        drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h404, 32'hBEEF0000, 32'h54);
        drive_mem(1'b1, 32'h77);
        #1;
        chk("b2b_st_req",   32'(dmem.dmem_req), 32'd1);
        chk("b2b_st_we",    32'(dmem.dmem_we),  32'd1);
        chk("b2b_st_addr",  dmem.dmem_addr,     32'h404);
        chk("b2b_st_stall", 32'(StallM),        32'd0);
        tick();
        chk("b2b_st_rw",  32'(RegWriteW), 32'd0);
        chk("b2b_st_rdw", ReadDataW,      32'hA5A50001);
        chk("b2b_st_pc4", PCPlus4W,       32'h54);

        // misaligned load
        drive_m(1'b1, 1'b0, 1'b1, 5'd6, 32'h102, 32'h0, 32'h58);
`ifdef MISALIGN_CHECK_EN
        drive_mem(1'b0, 32'h99);
        #1;
        chk("mis_req",   32'(dmem.dmem_req), 32'd0);
        chk("mis_stall", 32'(StallM),        32'd0);
        tick();
        chk("mis_flag", 32'(MisalignW), 32'd1);
        chk("mis_rw",   32'(RegWriteW), 32'd0);
        drive_m(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 32'h5C);
        drive_mem(1'b0, '0);
        tick();
        chk("mis_flag_clr", 32'(MisalignW), 32'd0);
`else
        drive_mem(1'b1, 32'h99);
        #1;
        chk("mis_req",  32'(dmem.dmem_req), 32'd1);
        chk("mis_addr", dmem.dmem_addr,     32'h102);
        tick();
        chk("mis_flag", 32'(MisalignW), 32'd0);
        chk("mis_rw",   32'(RegWriteW), 32'd1);
        chk("mis_rdw",  ReadDataW,      32'h99);
`endif

        // reset while BUSY after two wait cycles
        drive_m(1'b1, 1'b0, 1'b0, 5'd8, 32'h33, 32'h0, 32'h60);
        drive_mem(1'b0, '0);
        tick();
        drive_m(1'b1, 1'b0, 1'b1, 5'd2, 32'h300, 32'h0, 32'h64);
        tick();
        tick();
        chk("rstb_busy", 32'(ms_state), 32'(MS_BUSY));
        rst = 1'b0;
        #1;
        chk_w_zero("rstb");
        drive_m(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstb_req",   32'(dmem.dmem_req), 32'd0);
        chk("rstb_stall", 32'(StallM),        32'd0);
        tick();
        chk("rstb_after_rw", 32'(RegWriteW), 32'd0);
        chk("rstb_after_st", 32'(ms_state),  32'(MS_IDLE));

        // randomized instruction stream against a transaction-level model
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_rdata = '0;
        for (int n = 0; n < 150; n++) begin
            kind    = int'($urandom_range(0, 2));
            r_rd    = 5'($urandom);
            r_alu   = $urandom;
            r_wd    = $urandom;
            r_pc4   = $urandom;
            r_rdata = $urandom;
            r_rw    = (kind != 2);
            r_mw    = (kind == 2);
            r_rs    = (kind == 1);
            is_mem  = (kind != 0);
            if (is_mem) r_alu = r_alu & ~32'h3;
            waits = is_mem ? int'($urandom_range(0, 3)) : 0;
            if (kind == 1) model_rdata = r_rdata;
            exp_q.push_back({r_rw, r_rs, r_rd, r_alu, model_rdata, r_pc4});
            drive_m(r_rw, r_mw, r_rs, r_rd, r_alu, r_wd, r_pc4);
            for (int k = 0; k < waits; k++) begin
                drive_mem(1'b0, $urandom);
                #1;
                chk("rnd_wait_stall", 32'(StallM),        32'd1);
                chk("rnd_wait_req",   32'(dmem.dmem_req), 32'd1);
                tick();
                chk("rnd_bubble", 32'(RegWriteW), 32'd0);
            end
            drive_mem(is_mem ? 1'b1 : 1'($urandom), r_rdata);
            #1;
            chk("rnd_req",   32'(dmem.dmem_req), 32'(is_mem));
            chk("rnd_stall", 32'(StallM),        32'd0);
            tick();
            exp_w = exp_q.pop_front();
            got_w = {RegWriteW, ResultSrcW, RD_W, ALU_ResultW, ReadDataW, PCPlus4W};
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL rnd_w n=%0d actual=%h expected=%h", n, got_w, exp_w);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
